// File: rtl/pipe_div_pkg.sv
// pipe_div_pkg: shared definitions for the multi-cycle EXE-stage divider.
//   DIV_WIDTH  : default operand/quotient/remainder width
//   DIV_CNT_W  : default iteration counter width (2**DIV_CNT_W > DIV_WIDTH)
//   DIV_ITER   : iterations per division (one quotient bit per step)
//   div_state_t: controller state encoding
package pipe_div_pkg;

  localparam int unsigned DIV_WIDTH = 32;
  localparam int unsigned DIV_CNT_W = 6;
  localparam int unsigned DIV_ITER  = DIV_WIDTH;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } div_state_t;

endpackage

// File: rtl/pipe_div_negcond.sv
// pipe_div_negcond: combinational conditional two's-complement negate.
//   neg : 1 = output the negation of a, 0 = pass a through
//   a   : input value
//   y   : neg ? -a : a
module pipe_div_negcond #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             neg,
  input  logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] y
);

  always_comb begin
    y = neg ? (~a + WIDTH'(1)) : a;
  end

endmodule

// File: rtl/pipe_div.sv
// pipe_div: radix-2 restoring divider for DIV/DIVU beside the EXE stage.
// Divides operand magnitudes, then fixes signs (quotient negative when the
// operand signs differ, remainder takes the dividend's sign).
//   clk      : rising-edge clock
//   rst      : asynchronous active-low reset
//   start    : request pulse, sampled only when not busy (IDLE or DONE)
//   sign     : 1 = signed (DIV), 0 = unsigned (DIVU); sampled with start
//   dividend : rs operand; sampled with start
//   divisor  : rt operand; sampled with start
//   busy     : division in progress (pipeline stall)
//   done     : one-cycle pulse, q/r valid
//   q        : quotient (to LO), held until the next completion
//   r        : remainder (to HI), held until the next completion
//   counter  : iterations completed (debug/trace)
module pipe_div
  import pipe_div_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH,
  parameter int unsigned CNT_W = DIV_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sign,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic [CNT_W-1:0] counter
);

  div_state_t       state;
  logic             sa;
  logic             sb;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] dvs;

  logic [WIDTH-1:0] dd_mag;
  logic [WIDTH-1:0] dv_mag;
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;

  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic             fits;
  logic [WIDTH-1:0] step_rem;
  logic [WIDTH-1:0] step_quo;
  logic             last_step;

  // Operand magnitudes straight from the inputs so they can be latched on
  // the accepting edge.
  pipe_div_negcond #(.WIDTH(WIDTH)) u_neg_dividend (
    .neg (sign & dividend[WIDTH-1]),
    .a   (dividend),
    .y   (dd_mag)
  );

  pipe_div_negcond #(.WIDTH(WIDTH)) u_neg_divisor (
    .neg (sign & divisor[WIDTH-1]),
    .a   (divisor),
    .y   (dv_mag)
  );

  // One restoring step. The remainder is widened by one bit because a
  // shifted partial remainder can exceed WIDTH bits before the subtract.
  always_comb begin
    shifted  = {rem, quo[WIDTH-1]};
    trial    = shifted - {1'b0, dvs};
    fits     = ~trial[WIDTH];
    step_rem = fits ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
    step_quo = {quo[WIDTH-2:0], fits};
  end

  // Sign fix applied to the final step's result so q/r register on the
  // same edge that raises done.
  pipe_div_negcond #(.WIDTH(WIDTH)) u_neg_quo (
    .neg (sa ^ sb),
    .a   (step_quo),
    .y   (q_fix)
  );

  pipe_div_negcond #(.WIDTH(WIDTH)) u_neg_rem (
    .neg (sa),
    .a   (step_rem),
    .y   (r_fix)
  );

  assign last_step = (counter == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ST_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      q       <= '0;
      r       <= '0;
      counter <= '0;
      sa      <= 1'b0;
      sb      <= 1'b0;
      rem     <= '0;
      quo     <= '0;
      dvs     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state   <= ST_BUSY;
            busy    <= 1'b1;
            counter <= '0;
            sa      <= sign & dividend[WIDTH-1];
            sb      <= sign & divisor[WIDTH-1];
            quo     <= dd_mag;
            dvs     <= dv_mag;
            rem     <= '0;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_BUSY: begin
          rem     <= step_rem;
          quo     <= step_quo;
          counter <= counter + CNT_W'(1);
          if (last_step) begin
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            q     <= q_fix;
            r     <= r_fix;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_div.sv
// tb_pipe_div: directed-vector bench for pipe_div with hand-computed results.
module tb_pipe_div;

  logic        clk;
  logic        rst;
  logic        start;
  logic        sign;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] q;
  logic [31:0] r;
  logic [5:0]  counter;

  int vectors;
  int miscompares;

  pipe_div #(.WIDTH(32), .CNT_W(6)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .sign     (sign),
    .dividend (dividend),
    .divisor  (divisor),
    .busy     (busy),
    .done     (done),
    .q        (q),
    .r        (r),
    .counter  (counter)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive a start pulse; returns 1 ns after the accepting edge E0.
  task automatic issue(input logic s, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start    = 1'b1;
    sign     = s;
    dividend = a;
    divisor  = b;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Wait (bounded) for done; reports edges waited, busy-low cycles seen
  // before done, and any cycle with busy and done together.
  task automatic wait_done(output int cycles, output int gaps, output int overlap);
    cycles  = 0;
    gaps    = 0;
    overlap = 0;
    while (cycles < 40) begin
      @(posedge clk);
      #1;
      cycles++;
      if (busy && done) overlap++;
      if (done) break;
      if (!busy) gaps++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b0;
    start = 1'b0; sign = 1'b0; dividend = '0; divisor = '0;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if ({busy, done, q, r, counter} !== '0) begin
      miscompares++;
      $display("FAIL reset_state: busy=%b done=%b q=%h r=%h counter=%0d, want all zero",
               busy, done, q, r, counter);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_unsigned;
    int cyc, gaps, ov;
    issue(1'b0, 32'd100, 32'd7);
    vectors++;
    if (busy !== 1'b1 || counter !== 6'd0) begin
      miscompares++;
      $display("FAIL u_accept: busy=%b counter=%0d, want busy=1 counter=0", busy, counter);
    end
    wait_done(cyc, gaps, ov);
    vectors++;
    if (cyc !== 32 || gaps !== 0 || ov !== 0) begin
      miscompares++;
      $display("FAIL u_latency: edges=%0d gaps=%0d overlap=%0d, want 32/0/0", cyc, gaps, ov);
    end
    vectors++;
    if (q !== 32'd14 || r !== 32'd2 || counter !== 6'd32) begin
      miscompares++;
      $display("FAIL u_100_7: q=%h r=%h counter=%0d, want q=0000000e r=00000002 counter=32",
               q, r, counter);
    end
    @(posedge clk);
    #1;
    vectors++;
    if (done !== 1'b0 || busy !== 1'b0 || q !== 32'd14 || r !== 32'd2 || counter !== 6'd32) begin
      miscompares++;
      $display("FAIL u_after_done: done=%b busy=%b q=%h r=%h counter=%0d, want 0/0/0000000e/00000002/32",
               done, busy, q, r, counter);
    end
  endtask

  task automatic test_signed;
    int cyc, gaps, ov;
    issue(1'b1, 32'hFFFF_FFF9, 32'd2);
    wait_done(cyc, gaps, ov);
    vectors++;
    if (cyc !== 32 || q !== 32'hFFFF_FFFD || r !== 32'hFFFF_FFFF) begin
      miscompares++;
      $display("FAIL s_m7_2: edges=%0d q=%h r=%h, want 32 fffffffd ffffffff", cyc, q, r);
    end
    issue(1'b1, 32'd7, 32'hFFFF_FFFE);
    wait_done(cyc, gaps, ov);
    vectors++;
    if (cyc !== 32 || q !== 32'hFFFF_FFFD || r !== 32'd1) begin
      miscompares++;
      $display("FAIL s_7_m2: edges=%0d q=%h r=%h, want 32 fffffffd 00000001", cyc, q, r);
    end
    issue(1'b1, 32'hFFFF_FF9C, 32'd7);
    wait_done(cyc, gaps, ov);
    vectors++;
    if (cyc !== 32 || q !== 32'hFFFF_FFF2 || r !== 32'hFFFF_FFFE) begin
      miscompares++;
      $display("FAIL s_m100_7: edges=%0d q=%h r=%h, want 32 fffffff2 fffffffe", cyc, q, r);
    end
  endtask

  task automatic test_corners;
    int cyc, gaps, ov;
    issue(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(cyc, gaps, ov);
    vectors++;
    if (cyc !== 32 || q !== 32'h8000_0000 || r !== 32'd0) begin
      miscompares++;
      $display("FAIL c_overflow: edges=%0d q=%h r=%h, want 32 80000000 00000000", cyc, q, r);
    end
    issue(1'b0, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(cyc, gaps, ov);
    vectors++;
    if (cyc !== 32 || q !== 32'd0 || r !== 32'h8000_0000) begin
      miscompares++;
      $display("FAIL c_divu_big: edges=%0d q=%h r=%h, want 32 00000000 80000000", cyc, q, r);
    end
    issue(1'b0, 32'd5, 32'd0);
    wait_done(cyc, gaps, ov);
    vectors++;
    if (cyc !== 32 || q !== 32'hFFFF_FFFF || r !== 32'd5) begin
      miscompares++;
      $display("FAIL c_divu_zero: edges=%0d q=%h r=%h, want 32 ffffffff 00000005", cyc, q, r);
    end
    issue(1'b1, 32'hFFFF_FFFB, 32'd0);
    wait_done(cyc, gaps, ov);
    vectors++;
    if (cyc !== 32 || q !== 32'd1 || r !== 32'hFFFF_FFFB) begin
      miscompares++;
      $display("FAIL c_div_zero: edges=%0d q=%h r=%h, want 32 00000001 fffffffb", cyc, q, r);
    end
    issue(1'b0, 32'hFFFF_FFFF, 32'd1);
    wait_done(cyc, gaps, ov);
    vectors++;
    if (cyc !== 32 || q !== 32'hFFFF_FFFF || r !== 32'd0) begin
      miscompares++;
      $display("FAIL c_divu_by1: edges=%0d q=%h r=%h, want 32 ffffffff 00000000", cyc, q, r);
    end
  endtask

  task automatic test_start_while_busy;
    int cyc, gaps, ov;
    issue(1'b0, 32'd100, 32'd7);
    repeat (9) begin
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    start = 1'b1; sign = 1'b1; dividend = 32'd1000; divisor = 32'd10;
    @(posedge clk);
    #1;
    start = 1'b0;
    vectors++;
    if (busy !== 1'b1 || counter !== 6'd10) begin
      miscompares++;
      $display("FAIL busy_ignore_cnt: busy=%b counter=%0d, want busy=1 counter=10", busy, counter);
    end
    wait_done(cyc, gaps, ov);
    vectors++;
    if (cyc + 10 !== 32 || q !== 32'd14 || r !== 32'd2) begin
      miscompares++;
      $display("FAIL busy_ignore_res: edges=%0d q=%h r=%h, want 32 0000000e 00000002",
               cyc + 10, q, r);
    end
  endtask

  task automatic test_back_to_back;
    int cyc, gaps, ov;
    issue(1'b0, 32'd50, 32'd6);
    wait_done(cyc, gaps, ov);
    vectors++;
    if (cyc !== 32 || q !== 32'd8 || r !== 32'd2) begin
      miscompares++;
      $display("FAIL b2b_first: edges=%0d q=%h r=%h, want 32 00000008 00000002", cyc, q, r);
    end
    // Still inside the done cycle: start the next one.
    start = 1'b1; sign = 1'b1; dividend = 32'hFFFF_FF9C; divisor = 32'd7;
    @(posedge clk);
    #1;
    start = 1'b0;
    vectors++;
    if (busy !== 1'b1 || done !== 1'b0 || counter !== 6'd0 || q !== 32'd8 || r !== 32'd2) begin
      miscompares++;
      $display("FAIL b2b_accept: busy=%b done=%b counter=%0d q=%h r=%h, want 1/0/0/00000008/00000002",
               busy, done, counter, q, r);
    end
    repeat (16) begin
      @(posedge clk);
      #1;
    end
    vectors++;
    if (q !== 32'd8 || r !== 32'd2 || counter !== 6'd16) begin
      miscompares++;
      $display("FAIL b2b_hold: q=%h r=%h counter=%0d, want 00000008 00000002 16", q, r, counter);
    end
    wait_done(cyc, gaps, ov);
    vectors++;
    if (cyc + 16 !== 32 || ov !== 0 || q !== 32'hFFFF_FFF2 || r !== 32'hFFFF_FFFE) begin
      miscompares++;
      $display("FAIL b2b_second: edges=%0d overlap=%0d q=%h r=%h, want 32 0 fffffff2 fffffffe",
               cyc + 16, ov, q, r);
    end
  endtask

  task automatic test_reset_mid;
    int cyc, gaps, ov;
    int stray;
    issue(1'b0, 32'd123456, 32'd789);
    repeat (15) begin
      @(posedge clk);
      #1;
    end
    vectors++;
    if (counter !== 6'd15 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_mid_pre: counter=%0d busy=%b, want 15 1", counter, busy);
    end
    #2;
    rst = 1'b0;
    #1;
    vectors++;
    if ({busy, done, q, r, counter} !== '0) begin
      miscompares++;
      $display("FAIL rst_mid_clear: busy=%b done=%b q=%h r=%h counter=%0d, want all zero",
               busy, done, q, r, counter);
    end
    stray = 0;
    repeat (2) begin
      @(posedge clk);
      #1;
      if (done || busy) stray++;
    end
    @(negedge clk);
    rst = 1'b1;
    repeat (36) begin
      @(posedge clk);
      #1;
      if (done || busy) stray++;
    end
    vectors++;
    if (stray !== 0) begin
      miscompares++;
      $display("FAIL rst_mid_nodone: stray busy/done cycles=%0d, want 0", stray);
    end
    issue(1'b0, 32'd1000, 32'd10);
    wait_done(cyc, gaps, ov);
    vectors++;
    if (cyc !== 32 || q !== 32'd100 || r !== 32'd0) begin
      miscompares++;
      $display("FAIL rst_mid_fresh: edges=%0d q=%h r=%h, want 32 00000064 00000000", cyc, q, r);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_unsigned();
    test_signed();
    test_corners();
    test_start_while_busy();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
